addsub_serial: RTL and testbench
================================

ADDSUB_SERIAL -- requirements
Module: addsub_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand/result width in bits; must be a multiple of DIGIT and at least 2.
REQ-002 SHALL have parameter DIGIT, default 4: bits processed per cycle; must be at least 1.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port in_valid  input  1  operand request valid.
REQ-007 SHALL have port in_ready  output  1  block can accept a request.
REQ-008 SHALL have port a  input  WIDTH  first operand.
REQ-009 SHALL have port b  input  WIDTH  second operand.
REQ-010 SHALL have port sub  input  1  0 = a+b, 1 = a-b.
REQ-011 SHALL have port out_valid  output  1  result valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result.
REQ-013 SHALL have port result  output  WIDTH  sum or difference.
REQ-014 SHALL have port cout  output  1  unsigned carry out; for subtract, 1 = no borrow.
REQ-015 SHALL have port ovf  output  1  signed two's-complement overflow.
REQ-016 SHALL have port zero  output  1  result == 0.

Function
REQ-017 SHALL implement FSM states IDLE, RUN and DONE; in_ready = 1 only in IDLE, and out_valid = 1 only in DONE.
REQ-018 On the IDLE transfer edge (in_valid & in_ready), SHALL capture a, b XOR {WIDTH{sub}}, carry register = sub and digit counter = 0, then go to RUN.
REQ-019 In RUN, each cycle SHALL add digit k (bits k*DIGIT+DIGIT-1 .. k*DIGIT) with the carry register, store the sum digit into result bits of digit k and the carry out into the carry register, then increment k.
REQ-020 After digit N-1 (N = WIDTH/DIGIT), SHALL go to DONE; out_valid rises exactly N cycles after the transfer edge.
REQ-021 SHALL set cout = final carry and ovf = (carry into MSB) XOR (carry out of MSB), latched at the last RUN cycle.
REQ-022 SHALL compute zero from the final presented result, after any saturation.
REQ-023 In DONE, result, cout, ovf and zero SHALL hold stable while out_ready = 0; on out_valid & out_ready, SHALL go to IDLE.
REQ-024 A new request SHALL NOT be accepted on the same edge a result is consumed; minimum issue interval is N+2 cycles.
REQ-025 Operand and sub changes after the transfer edge SHALL have no effect on the current operation.
REQ-026 in_valid in RUN or DONE SHALL be ignored, with in_ready = 0.

Reset
REQ-027 While rst = 1 at a clock edge, SHALL go to IDLE and clear counter and carry.
REQ-028 Reset values SHALL be: in_ready = 1, out_valid = 0, result = 0, cout = 0, ovf = 0, zero = 0.
REQ-029 Reset in RUN or DONE SHALL abandon the operation with no out_valid pulse; a result pending in DONE is lost.

Configuration
REQ-030 Macro ADDSUB_SAT_EN defined: when ovf = 1, result SHALL saturate to the signed max 0111..1 if the MSB of a (the sign of the true result) is 0, else to the signed min 1000..0; ovf is still reported.
REQ-031 Macro ADDSUB_SAT_EN undefined: result SHALL be the wrapped modulo-2^WIDTH value, and no saturation logic SHALL be present.

Structure
REQ-032 Package addsub_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and a function computing N = WIDTH/DIGIT.
REQ-033 Sub-module digit_adder (DIGIT-bit ripple slice with carry in, carry out and carry into MSB) SHALL be instantiated once and reused each RUN cycle.
REQ-034 SHALL include an elaboration-time check for WIDTH % DIGIT == 0.

Verification (WIDTH=16, DIGIT=4)
REQ-035 0x1234 + 0x0FFF SHALL give 0x2233, cout=0, ovf=0, zero=0, with out_valid exactly 4 cycles after the transfer edge.
REQ-036 0x7FFF + 0x0001 SHALL give 0x8000 with ovf=1; with ADDSUB_SAT_EN defined, SHALL give 0x7FFF with ovf=1.
REQ-037 0x0005 - 0x0005 SHALL give 0x0000, zero=1, cout=1; 0x0000 - 0x0001 SHALL give 0xFFFF, cout=0, ovf=0.
REQ-038 0x8000 - 0x0001 SHALL give 0x7FFF with ovf=1; with ADDSUB_SAT_EN defined, SHALL give 0x8000.
REQ-039 Holding out_ready=0 for 5 cycles in DONE SHALL keep result and flags stable and in_ready=0; the held in_valid SHALL be accepted only after return to IDLE.
REQ-040 rst pulsed in the 2nd RUN cycle SHALL produce no out_valid and all outputs at reset values; the next request SHALL then complete correctly.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
// Holds the controller state encoding and the digit-count arithmetic.
// Combinational only; no latency or backpressure.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of digit slices needed to cover one operand.
    function automatic int num_digits(input int width, input int digit);
        return width / digit;
    endfunction

    // Digit counter width; at least one bit even for a single-digit build.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/addsub_serial_digit_adder.sv
// DIGIT-bit ripple-carry slice used once per cycle by the serial adder.
// Purely combinational (0 cycles); no backpressure.
// Ports: a, b, cin in; sum, cout, cmsb (carry into the slice MSB) out.
module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [DIGIT:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < DIGIT; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
    end

    assign cout = c[DIGIT];
    // Carry into the top bit of this slice; on the last digit this is the
    // carry into the operand sign bit, needed for signed overflow.
    assign cmsb = c[DIGIT-1];

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial add/subtract of two WIDTH-bit operands, DIGIT bits per cycle.
// Latency: out_valid rises WIDTH/DIGIT cycles after the accepting edge.
// Backpressure: one operation in flight; in_ready only in IDLE, result held in DONE until out_ready.
// Ports: clk, rst (sync, active-high); in_valid/in_ready with a, b, sub;
//        out_valid/out_ready with result, cout, ovf, zero.
// Optional: define ADDSUB_SAT_EN to saturate result on signed overflow.
module addsub_serial
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int             N      = num_digits(WIDTH, DIGIT);
    localparam int             KW     = cnt_width(N);
    localparam logic [KW-1:0]  K_LAST = KW'(N - 1);

    generate
        if ((WIDTH % DIGIT) != 0 || WIDTH < 2 || DIGIT < 1) begin : g_bad_params
            $error("addsub_serial: WIDTH must be a multiple of DIGIT, WIDTH >= 2, DIGIT >= 1");
        end
    endgenerate

    state_t          state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;      // already inverted for subtract
    logic             carry;
    logic [KW-1:0]    k;

    logic [DIGIT-1:0] d_a;
    logic [DIGIT-1:0] d_b;
    logic [DIGIT-1:0] d_sum;
    logic             d_cout;
    logic             d_cmsb;
    logic             ovf_now;
    logic [WIDTH-1:0] full_sum;
    logic [WIDTH-1:0] final_res;

    always_comb begin
        d_a = a_r[int'(k) * DIGIT +: DIGIT];
        d_b = b_r[int'(k) * DIGIT +: DIGIT];
    end

    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a    (d_a),
        .b    (d_b),
        .cin  (carry),
        .sum  (d_sum),
        .cout (d_cout),
        .cmsb (d_cmsb)
    );

    // Only meaningful on the last digit, where the slice MSB is the sign bit.
    assign ovf_now = d_cout ^ d_cmsb;

    // Complete wrapped result as it will stand after the current digit lands;
    // used on the last RUN cycle so saturation and zero see the whole word.
    always_comb begin
        full_sum = result;
        full_sum[int'(k) * DIGIT +: DIGIT] = d_sum;
    end

`ifdef ADDSUB_SAT_EN
    // On overflow the true result has the sign of a (both operands agree).
    always_comb begin
        final_res = full_sum;
        if (ovf_now) begin
            final_res = a_r[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                     : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign final_res = full_sum;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_r       <= '0;
            b_r       <= '0;
            carry     <= 1'b0;
            k         <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r      <= a;
                        b_r      <= b ^ {WIDTH{sub}};
                        carry    <= sub;   // +1 completes the two's complement
                        k        <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    result[int'(k) * DIGIT +: DIGIT] <= d_sum;
                    carry <= d_cout;
                    k     <= k + 1'b1;
                    if (k == K_LAST) begin
                        result    <= final_res;
                        cout      <= d_cout;
                        ovf       <= ovf_now;
                        zero      <= (final_res == '0);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // in_ready rises one edge after consumption, so no new
                    // request can be taken on the consuming edge.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_serial.sv
// Self-checking bench for addsub_serial (WIDTH=16, DIGIT=4).
// Expected results come from an arithmetic model pushed to a scoreboard queue.
// Ports driven from one initial block; outputs sampled 1ns after the rising edge.
module tb_addsub_serial;

    localparam int WIDTH = 16;
    localparam int DIGIT = 4;
    localparam int N     = WIDTH / DIGIT;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        cout;
    logic        ovf;
    logic        zero;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Scoreboard entries: {result, cout, ovf, zero}
    logic [18:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    addsub_serial #(
        .WIDTH (WIDTH),
        .DIGIT (DIGIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    function automatic logic [18:0] model(input logic [15:0] x, input logic [15:0] y, input logic s);
        logic [15:0] yy;
        logic [16:0] t;
        logic        v;
        logic [15:0] r;
        yy = s ? ~y : y;
        t  = {1'b0, x} + {1'b0, yy} + {16'h0, s};
        v  = (x[15] == yy[15]) && (t[15] != x[15]);
        r  = t[15:0];
`ifdef ADDSUB_SAT_EN
        if (v) r = x[15] ? 16'h8000 : 16'h7FFF;
`endif
        return {r, t[16], v, (r == 16'h0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request, wait (bounded) for acceptance, record the expectation.
    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic s, output bit ok);
        int n;
        n = 0;
        a = x; b = y; sub = s; in_valid = 1'b1;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        ok = in_ready;
        if (ok) begin
            tick();
            exp_q.push_back(model(x, y, s));
        end
        // Scramble operands after the transfer edge; they must not matter.
        in_valid = 1'b0;
        a   = 16'($urandom);
        b   = 16'($urandom);
        sub = 1'($urandom);
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic s,
                          output bit ok, output int lat, output logic [18:0] got,
                          output logic [18:0] e);
        send(x, y, s, ok);
        wait_out(lat);
        got = {result, cout, ovf, zero};
        e   = (ok && exp_q.size() > 0) ? exp_q.pop_front() : 19'h0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = 16'h0; b = 16'h0; sub = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if ({in_ready, out_valid, result, cout, ovf, zero} !== {1'b1, 1'b0, 16'h0, 3'b000}) begin
            errors++;
            $display("FAIL reset_values got=%h exp=%h", {in_ready, out_valid, result, cout, ovf, zero},
                     {1'b1, 1'b0, 16'h0, 3'b000});
        end
    endtask

    task automatic test_directed();
        logic [15:0] ta[6] = '{16'h1234, 16'h7FFF, 16'h0005, 16'h0000, 16'h8000, 16'hFFFF};
        logic [15:0] tb[6] = '{16'h0FFF, 16'h0001, 16'h0005, 16'h0001, 16'h0001, 16'h0001};
        logic        ts[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        bit ok; int lat; logic [18:0] got; logic [18:0] e;
        for (int i = 0; i < 6; i++) begin
            run_op(ta[i], tb[i], ts[i], ok, lat, got, e);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL directed_accept case=%0d in_ready=%b exp=1", i, in_ready);
            end
            checks++;
            if (lat !== N) begin
                errors++;
                $display("FAIL directed_latency case=%0d got=%0d exp=%0d", i, lat, N);
            end
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL directed_result case=%0d got={r=%h c=%b o=%b z=%b} exp={r=%h c=%b o=%b z=%b}",
                         i, got[18:3], got[2], got[1], got[0], e[18:3], e[2], e[1], e[0]);
            end
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL directed_idle case=%0d in_ready=%b out_valid=%b exp=1/0", i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_hold();
        bit ok; int lat; logic [18:0] e; logic [18:0] got;
        send(16'h4321, 16'h1111, 1'b1, ok);
        wait_out(lat);
        e   = (ok && exp_q.size() > 0) ? exp_q.pop_front() : 19'h0;
        got = {result, cout, ovf, zero};
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL hold_first_result got=%h exp=%h", got, e);
        end
        a = 16'h0100; b = 16'h0011; sub = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({result, cout, ovf, zero} !== e || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL hold_stable cycle=%0d got=%h rdy=%b vld=%b exp=%h rdy=0 vld=1",
                         i, {result, cout, ovf, zero}, in_ready, out_valid, e);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_consume in_ready=%b out_valid=%b exp=1/0", in_ready, out_valid);
        end
        exp_q.push_back(model(16'h0100, 16'h0011, 1'b0));
        tick();
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_accept_after_idle in_ready=%b exp=0", in_ready);
        end
        wait_out(lat);
        checks++;
        if (lat !== N) begin
            errors++;
            $display("FAIL hold_second_latency got=%0d exp=%0d", lat, N);
        end
        e   = (exp_q.size() > 0) ? exp_q.pop_front() : 19'h0;
        checks++;
        if ({result, cout, ovf, zero} !== e) begin
            errors++;
            $display("FAIL hold_second_result got=%h exp=%h", {result, cout, ovf, zero}, e);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit ok; bit seen; int lat; logic [18:0] got; logic [18:0] e;
        send(16'hAAAA, 16'h1111, 1'b0, ok);
        tick();          // first RUN cycle
        rst = 1'b1;
        tick();          // second RUN cycle sees reset
        rst = 1'b0;
        exp_q.delete();  // operation abandoned
        checks++;
        if ({in_ready, out_valid, result, cout, ovf, zero} !== {1'b1, 1'b0, 16'h0, 3'b000}) begin
            errors++;
            $display("FAIL midreset_values got=%h exp=%h", {in_ready, out_valid, result, cout, ovf, zero},
                     {1'b1, 1'b0, 16'h0, 3'b000});
        end
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL midreset_no_valid seen=%b exp=0", seen);
        end
        run_op(16'h0F0F, 16'h00F1, 1'b0, ok, lat, got, e);
        checks++;
        if (lat !== N) begin
            errors++;
            $display("FAIL midreset_next_latency got=%0d exp=%0d", lat, N);
        end
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL midreset_next_result got=%h exp=%h", got, e);
        end
    endtask

    task automatic test_back_to_back();
        int prev; int stamp; int n; logic [15:0] x; logic [15:0] y; logic s; logic [18:0] e;
        out_ready = 1'b1;
        prev = -1;
        for (int i = 0; i < 8; i++) begin
            x = 16'($urandom); y = 16'($urandom); s = 1'($urandom);
            n = 0;
            while (!in_ready && n < 40) begin
                tick();
                n++;
            end
            a = x; b = y; sub = s; in_valid = 1'b1;
            exp_q.push_back(model(x, y, s));
            tick();
            stamp = cyc;
            if (prev >= 0) begin
                checks++;
                if (stamp - prev !== N + 2) begin
                    errors++;
                    $display("FAIL b2b_interval op=%0d got=%0d exp=%0d", i, stamp - prev, N + 2);
                end
            end
            prev = stamp;
            n = 0;
            while (!out_valid && n < 40) begin
                tick();
                n++;
            end
            e = exp_q.pop_front();
            checks++;
            if ({result, cout, ovf, zero} !== e) begin
                errors++;
                $display("FAIL b2b_result op=%0d got=%h exp=%h", i, {result, cout, ovf, zero}, e);
            end
            tick();      // consumed here; in_ready returns
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
